// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier operand feeder.
package mult_pkg;

  localparam int unsigned OP_W             = 4;
  localparam int unsigned PROD_W           = 8;
  localparam int unsigned ERR_W            = 8;
  localparam int unsigned START_CYCLES_DEF = 2;
  localparam int unsigned MUL_CYCLES_DEF   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_START,
    ST_WAIT,
    ST_HOLD
  } state_t;

  // One queued operand pair as stored in the FIFO
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operand_t;

  // Reference product used by the built-in checker
  function automatic logic [PROD_W-1:0] ref_product(input logic [OP_W-1:0] a,
                                                    input logic [OP_W-1:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous operand FIFO with registered full/empty flags.
module mult_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  // Occupancy after this edge; simultaneous push and pop cancel
  always_comb begin
    count_d = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Storage array, written at the tail pointer
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/mult_feeder.sv
// Operand sequencer: queues operand pairs, drives one multiply job at a time
// and presents each product with its operands on a result stream.
module mult_feeder
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned START_CYCLES = START_CYCLES_DEF,
  parameter int unsigned MUL_CYCLES   = MUL_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              mul_clr,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_a,
  output logic [OP_W-1:0]   out_b,
  output logic [PROD_W-1:0] out_product,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned CYC_MAX = (START_CYCLES > MUL_CYCLES) ? START_CYCLES : MUL_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CYC_MAX) + 1;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              fifo_full;
  logic              fifo_empty;
  operand_t          head_c;
  operand_t          wr_op_c;
  logic              push_c;
  logic              pop_c;

  logic              mul_clr_d;
  logic              mul_start_d;
  logic [OP_W-1:0]   mul_a_d;
  logic [OP_W-1:0]   mul_b_d;
  logic              out_valid_d;
  logic [OP_W-1:0]   out_a_d;
  logic [OP_W-1:0]   out_b_d;
  logic [PROD_W-1:0] out_product_d;
  logic [ERR_W-1:0]  err_count_d;

  // Ready mirrors the registered full flag of the FIFO
  assign in_ready  = !fifo_full;
  assign push_c    = in_valid && !fifo_full;
  assign wr_op_c.a = in_a;
  assign wr_op_c.b = in_b;

  mult_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(operand_t))
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_c),
    .pop    (pop_c),
    .wdata  (wr_op_c),
    .head_c (head_c),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Job sequencing: next state, counter and next values of every output register
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pop_c         = 1'b0;
    mul_clr_d     = 1'b0;
    mul_start_d   = 1'b0;
    mul_a_d       = mul_a;
    mul_b_d       = mul_b;
    out_valid_d   = out_valid;
    out_a_d       = out_a;
    out_b_d       = out_b;
    out_product_d = out_product;
    err_count_d   = err_count;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          mul_a_d   = head_c.a;
          mul_b_d   = head_c.b;
          mul_clr_d = 1'b1;
          state_d   = ST_CLR;
        end
      end
      ST_CLR: begin
        mul_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          mul_start_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
          out_valid_d   = 1'b1;
          out_a_d       = mul_a;
          out_b_d       = mul_b;
          out_product_d = mul_product;
          if ((mul_product != ref_product(mul_a, mul_b)) && (err_count != '1)) begin
            err_count_d = err_count + ERR_W'(1);
          end
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any job in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mul_clr     <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_product <= '0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_clr     <= mul_clr_d;
      mul_start   <= mul_start_d;
      mul_a       <= mul_a_d;
      mul_b       <= mul_b_d;
      out_valid   <= out_valid_d;
      out_a       <= out_a_d;
      out_b       <= out_b_d;
      out_product <= out_product_d;
      err_count   <= err_count_d;
    end
  end

endmodule
